oc_bank_arbiter: RTL and testbench
==================================

OC_BANK_ARBITER -- requirements
Module: oc_bank_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning): NUM_BANKS, 4, register-file banks; FIFO_DEPTH, 4, per-bank request queue entries; ROW_W, 6, row address width per bank.
REQ-002 SHALL have port clk, input, 1, sole clock; all state on posedge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports alloc_vld in 1, alloc_oc in 2 (target collector unit), alloc_rdy out 1 (allocation accepted when alloc_vld & alloc_rdy).
REQ-005 SHALL have ports src1_vld in 1, src1_bank in 2, src1_row in ROW_W, src2_vld in 1, src2_bank in 2, src2_row in ROW_W.
REQ-006 SHALL have ports wb_vld in 1, wb_bank in 2 (writeback owns that bank's port this cycle).
REQ-007 SHALL have per-bank ports rf_rd_en_n out 1, rf_rd_row_n out ROW_W, rf_rd_data_n in 256 (valid one cycle after rf_rd_en_n), n=0..3.
REQ-008 SHALL have per-bank ports bk_n_data out 256, bk_n_ocid out 3 ({oc[1:0], operand}), bk_n_vld out 1, same_OC_n out 1.

Function
REQ-009 SHALL keep one FIFO per bank; entry = {oc[1:0], operand bit, row, same flag}.
REQ-010 SHALL on accepted alloc enqueue src1 as operand 0 into FIFO[src1_bank] and src2 as operand 1 into FIFO[src2_bank], each only if its vld is set.
REQ-011 SHALL, when both srcs valid with equal bank and equal row, enqueue one entry (operand 0, same=1).
REQ-012 SHALL, when both srcs valid with equal bank and different rows, enqueue src1 then src2 in the same cycle (two slots).
REQ-013 SHALL drive alloc_rdy combinationally high only if every FIFO has free slots >= entries the current request would add; no partial enqueue.
REQ-014 SHALL each cycle, per bank, pop head and assert rf_rd_en_n with rf_rd_row_n = head row, unless FIFO empty or (wb_vld & wb_bank==n).
REQ-015 SHALL register popped {ocid, same} and, one cycle later, drive bk_n_vld=1, bk_n_data=rf_rd_data_n, bk_n_ocid, same_OC_n for exactly one cycle.
REQ-016 SHALL give latency: alloc accepted cycle N -> earliest rf_rd_en_n at N+1 -> bk_n_vld at N+2.
REQ-017 SHALL drive bk_n_ocid/same_OC_n to 0 when bk_n_vld=0; bk_n_data holds last value.
REQ-018 SHALL allow enqueue and pop on the same FIFO in one cycle; full FIFO with a pop still refuses alloc (alloc_rdy uses pre-pop count).
REQ-019 SHALL keep per-bank order FIFO; no reordering across a bank; banks independent.
REQ-020 SHALL wrap FIFO pointers modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.

Reset
REQ-021 SHALL on rst clear all FIFO pointers/counts, bk_n_vld, same_OC_n, bk_n_ocid, rf_rd_en_n to 0; data registers need no reset.
REQ-022 SHALL on rst mid-operation drop queued and in-flight reads; no bk_n_vld the cycle after rst deasserts.
REQ-023 SHALL ignore alloc_vld while rst is high; alloc_rdy is 1 in the first cycle after reset.

Structure
REQ-024 SHALL place NUM_BANKS, FIFO_DEPTH, ROW_W, and the request-entry typedef in the shared operand-collector package.
REQ-025 SHALL instantiate sub-module oc_bank_req_fifo (2-write/1-read, count output) once per bank.

Verification
REQ-026 SHALL test: alloc oc=2, src1 bank1 row5, src2 bank3 row9 at cycle N -> bk_1_vld ocid=3'b100 and bk_3_vld ocid=3'b101 at N+2.
REQ-027 SHALL test: src1=src2=bank0 row7 -> single rf_rd_en_0, bk_0_vld ocid=3'b000 with same_OC_0=1 at N+2.
REQ-028 SHALL test: src1 bank2 row1, src2 bank2 row4 -> bk_2_vld at N+2 (operand 0) and N+3 (operand 1).
REQ-029 SHALL test: wb_vld on bank1 for 3 cycles with request queued -> rf_rd_en_1 delayed 3 cycles, then data delivered.
REQ-030 SHALL test: fill FIFO[0] to 4 with wb_vld blocking -> alloc_rdy=0 for bank0 request, alloc_rdy=1 for bank2-only request.
REQ-031 SHALL test: rst asserted with 3 queued entries -> no bk_n_vld afterwards, alloc_rdy=1 after reset.

Source files
------------

// File: rtl/oc_bank_arbiter_pkg.sv
// Operand-collector bank arbiter: shared sizes,
// request-queue entry type and pointer helper.
package oc_bank_arbiter_pkg;

  localparam int NUM_BANKS  = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int ROW_W      = 6;
  localparam int DATA_W     = 256;

  typedef struct packed {
    logic [1:0]       oc;
    logic             opnd;
    logic [ROW_W-1:0] row;
    logic             same;
  } oc_req_t;

  function automatic int wrap_inc(int p, int n, int d);
    return (p + n) % d;
  endfunction

endpackage

// File: rtl/oc_bank_arbiter_if.sv
// Allocation request bundle: operand sources,
// collector id, ready, and writeback port claim.
interface oc_bank_arbiter_if #(
  parameter int ROW_W = oc_bank_arbiter_pkg::ROW_W
);
  logic             alloc_vld;
  logic [1:0]       alloc_oc;
  logic             alloc_rdy;
  logic             src1_vld;
  logic [1:0]       src1_bank;
  logic [ROW_W-1:0] src1_row;
  logic             src2_vld;
  logic [1:0]       src2_bank;
  logic [ROW_W-1:0] src2_row;
  logic             wb_vld;
  logic [1:0]       wb_bank;

  modport master (
    output alloc_vld, alloc_oc,
    output src1_vld, src1_bank, src1_row,
    output src2_vld, src2_bank, src2_row,
    output wb_vld, wb_bank,
    input  alloc_rdy
  );

  modport slave (
    input  alloc_vld, alloc_oc,
    input  src1_vld, src1_bank, src1_row,
    input  src2_vld, src2_bank, src2_row,
    input  wb_vld, wb_bank,
    output alloc_rdy
  );
endinterface

// File: rtl/oc_bank_req_fifo.sv
// Per-bank request queue: two writes and one read
// per cycle, occupancy exposed for admission control.
module oc_bank_req_fifo
  import oc_bank_arbiter_pkg::*;
#(
  parameter  int DEPTH = FIFO_DEPTH,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr0_en,
  input  oc_req_t       i_wr0_data,
  input  logic          i_wr1_en,
  input  oc_req_t       i_wr1_data,
  input  logic          i_rd_en,
  output oc_req_t       o_head,
  output logic [CW-1:0] o_count,
  output logic          o_empty
);

  oc_req_t       r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic [PW-1:0] w_wptr1;
  logic [1:0]    w_nwr;
  logic          w_rd;

  assign w_rd    = i_rd_en & (r_count != '0);
  assign w_nwr   = {1'b0, i_wr0_en} + {1'b0, i_wr1_en};
  assign w_wptr1 = PW'(wrap_inc(int'(r_wptr), 1, DEPTH));

  // src2 lands behind src1 when both target this bank
  always_ff @(posedge clk) begin
    if (i_wr0_en)
      r_mem[r_wptr] <= i_wr0_data;
    if (i_wr1_en)
      r_mem[i_wr0_en ? w_wptr1 : r_wptr] <= i_wr1_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= PW'(wrap_inc(int'(r_wptr),
                              int'(w_nwr), DEPTH));
      if (w_rd)
        r_rptr <= PW'(wrap_inc(int'(r_rptr), 1, DEPTH));
      r_count <= r_count + CW'(w_nwr) - CW'(w_rd);
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/oc_bank_arbiter.sv
// Register-file bank arbiter: queues operand reads per
// bank and returns data tagged with collector/operand.
module oc_bank_arbiter #(
  parameter int NUM_BANKS  = oc_bank_arbiter_pkg::NUM_BANKS,
  parameter int FIFO_DEPTH = oc_bank_arbiter_pkg::FIFO_DEPTH,
  parameter int ROW_W      = oc_bank_arbiter_pkg::ROW_W
) (
  input  logic                            clk,
  input  logic                            rst,
  oc_bank_arbiter_if.slave                req,
  output logic [NUM_BANKS-1:0]            rf_rd_en,
  output logic [NUM_BANKS-1:0][ROW_W-1:0] rf_rd_row,
  input  logic [NUM_BANKS-1:0][255:0]     rf_rd_data,
  output logic [NUM_BANKS-1:0][255:0]     bk_data,
  output logic [NUM_BANKS-1:0][2:0]       bk_ocid,
  output logic [NUM_BANKS-1:0]            bk_vld,
  output logic [NUM_BANKS-1:0]            same_OC
);
  import oc_bank_arbiter_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          w_merge;
  logic          w_rdy;
  logic          w_acc;
  oc_req_t       w_d0;
  oc_req_t       w_d1;
  logic [NUM_BANKS-1:0] w_s1;
  logic [NUM_BANKS-1:0] w_s2;
  logic [NUM_BANKS-1:0] w_pop;
  logic [NUM_BANKS-1:0] w_empty;
  logic [1:0]    w_need [NUM_BANKS];
  logic [CW-1:0] w_cnt  [NUM_BANKS];
  oc_req_t       w_head [NUM_BANKS];

  // same bank and row: one read serves both operands
  assign w_merge = req.src1_vld & req.src2_vld
                 & (req.src1_bank == req.src2_bank)
                 & (req.src1_row == req.src2_row);

  assign w_d0 = '{oc: req.alloc_oc, opnd: 1'b0,
                  row: req.src1_row, same: w_merge};
  assign w_d1 = '{oc: req.alloc_oc, opnd: 1'b1,
                  row: req.src2_row, same: 1'b0};

  always_comb begin
    w_rdy = 1'b1;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (int'(w_cnt[b]) + int'(w_need[b]) > FIFO_DEPTH)
        w_rdy = 1'b0;
    end
  end

  assign req.alloc_rdy = w_rdy;
  assign w_acc = req.alloc_vld & w_rdy & ~rst;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic         r_vld;
    logic [2:0]   r_ocid;
    logic         r_same;
    logic [255:0] r_data;

    assign w_s1[b] = req.src1_vld
                   & (req.src1_bank == 2'(b));
    assign w_s2[b] = req.src2_vld
                   & (req.src2_bank == 2'(b)) & ~w_merge;
    assign w_need[b] = {1'b0, w_s1[b]} + {1'b0, w_s2[b]};

    assign w_pop[b] = ~w_empty[b] & ~rst
                    & ~(req.wb_vld & (req.wb_bank == 2'(b)));

    oc_bank_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_wr0_en   (w_acc & w_s1[b]),
      .i_wr0_data (w_d0),
      .i_wr1_en   (w_acc & w_s2[b]),
      .i_wr1_data (w_d1),
      .i_rd_en    (w_pop[b]),
      .o_head     (w_head[b]),
      .o_count    (w_cnt[b]),
      .o_empty    (w_empty[b])
    );

    assign rf_rd_en[b]  = w_pop[b];
    assign rf_rd_row[b] = w_head[b].row;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld  <= 1'b0;
        r_ocid <= 3'b0;
        r_same <= 1'b0;
      end else begin
        r_vld  <= w_pop[b];
        r_ocid <= w_pop[b] ? {w_head[b].oc, w_head[b].opnd}
                           : 3'b0;
        r_same <= w_pop[b] & w_head[b].same;
      end
    end

    always_ff @(posedge clk) begin
      if (r_vld)
        r_data <= rf_rd_data[b];
    end

    assign bk_vld[b]  = r_vld;
    assign bk_ocid[b] = r_ocid;
    assign same_OC[b] = r_same;
    assign bk_data[b] = r_vld ? rf_rd_data[b] : r_data;
  end

endmodule

// File: tb/tb_oc_bank_arbiter.sv
// Directed bench for oc_bank_arbiter with a simple
// register-file model returning row-tagged data.
module tb_oc_bank_arbiter;

  logic clk = 1'b0;
  logic rst;

  logic [3:0]        rf_rd_en;
  logic [3:0][5:0]   rf_rd_row;
  logic [3:0][255:0] rf_rd_data;
  logic [3:0][255:0] bk_data;
  logic [3:0][2:0]   bk_ocid;
  logic [3:0]        bk_vld;
  logic [3:0]        same_OC;

  int n_err = 0;
  int n_chk = 0;

  logic [5:0] rows [4] = '{6'd1, 6'd2, 6'd3, 6'd4};

  oc_bank_arbiter_if bus ();

  oc_bank_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req        (bus),
    .rf_rd_en   (rf_rd_en),
    .rf_rd_row  (rf_rd_row),
    .rf_rd_data (rf_rd_data),
    .bk_data    (bk_data),
    .bk_ocid    (bk_ocid),
    .bk_vld     (bk_vld),
    .same_OC    (same_OC)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] rfval(int b, logic [5:0] r);
    return {224'h0, 8'hDA, 8'(b), 10'h0, r};
  endfunction

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (rf_rd_en[b])
        rf_rd_data[b] <= rfval(b, rf_rd_row[b]);
  end

  task automatic check(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alloc_vld = 1'b0;
    bus.alloc_oc  = 2'd0;
    bus.src1_vld  = 1'b0;
    bus.src1_bank = 2'd0;
    bus.src1_row  = 6'd0;
    bus.src2_vld  = 1'b0;
    bus.src2_bank = 2'd0;
    bus.src2_row  = 6'd0;
    bus.wb_vld    = 1'b0;
    bus.wb_bank   = 2'd0;
  endtask

  task automatic alloc(input logic [1:0] oc,
                       input logic v1, input logic [1:0] b1,
                       input logic [5:0] r1,
                       input logic v2, input logic [1:0] b2,
                       input logic [5:0] r2);
    bus.alloc_vld = 1'b1;
    bus.alloc_oc  = oc;
    bus.src1_vld  = v1;
    bus.src1_bank = b1;
    bus.src1_row  = r1;
    bus.src2_vld  = v2;
    bus.src2_bank = b2;
    bus.src2_row  = r2;
  endtask

  task automatic wb(input logic v, input logic [1:0] b);
    bus.wb_vld  = v;
    bus.wb_bank = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    repeat (3) cyc();
    rst = 1'b0;
    #1;
    check("rst_rdy", bus.alloc_rdy, 1'b1);
    check("rst_vld", bk_vld, 4'b0);
    check("rst_rden", rf_rd_en, 4'b0);
    check("rst_ocid", bk_ocid, 12'b0);

    // two banks, one operand each
    cyc(); alloc(2'd2, 1, 2'd1, 6'd5, 1, 2'd3, 6'd9); #1;
    check("t1_rdy", bus.alloc_rdy, 1'b1);
    cyc(); idle(); #1;
    check("t1_rden", rf_rd_en, 4'b1010);
    check("t1_row1", rf_rd_row[1], 6'd5);
    check("t1_row3", rf_rd_row[3], 6'd9);
    cyc(); #1;
    check("t1_vld", bk_vld, 4'b1010);
    check("t1_ocid1", bk_ocid[1], 3'b100);
    check("t1_ocid3", bk_ocid[3], 3'b101);
    check("t1_data1", bk_data[1], rfval(1, 6'd5));
    check("t1_data3", bk_data[3], rfval(3, 6'd9));
    check("t1_same", same_OC, 4'b0);
    cyc(); #1;
    check("t1_vld_off", bk_vld, 4'b0);
    check("t1_ocid_off", bk_ocid, 12'b0);
    check("t1_hold", bk_data[1], rfval(1, 6'd5));

    // same bank, same row: merged read
    cyc(); alloc(2'd0, 1, 2'd0, 6'd7, 1, 2'd0, 6'd7); #1;
    cyc(); idle(); #1;
    check("t2_rden", rf_rd_en, 4'b0001);
    check("t2_row0", rf_rd_row[0], 6'd7);
    cyc(); #1;
    check("t2_vld", bk_vld, 4'b0001);
    check("t2_ocid0", bk_ocid[0], 3'b000);
    check("t2_same", same_OC, 4'b0001);
    check("t2_single", rf_rd_en, 4'b0);
    check("t2_data0", bk_data[0], rfval(0, 6'd7));
    cyc(); #1;
    check("t2_vld_off", bk_vld, 4'b0);
    check("t2_same_off", same_OC, 4'b0);

    // same bank, different rows: back to back
    cyc(); alloc(2'd1, 1, 2'd2, 6'd1, 1, 2'd2, 6'd4); #1;
    cyc(); idle(); #1;
    check("t3_rden_a", rf_rd_en, 4'b0100);
    check("t3_row_a", rf_rd_row[2], 6'd1);
    cyc(); #1;
    check("t3_vld_a", bk_vld, 4'b0100);
    check("t3_ocid_a", bk_ocid[2], 3'b010);
    check("t3_data_a", bk_data[2], rfval(2, 6'd1));
    check("t3_rden_b", rf_rd_en, 4'b0100);
    check("t3_row_b", rf_rd_row[2], 6'd4);
    cyc(); #1;
    check("t3_vld_b", bk_vld, 4'b0100);
    check("t3_ocid_b", bk_ocid[2], 3'b011);
    check("t3_data_b", bk_data[2], rfval(2, 6'd4));
    cyc(); #1;
    check("t3_vld_off", bk_vld, 4'b0);

    // writeback holds bank1 for three cycles
    cyc(); alloc(2'd3, 1, 2'd1, 6'd2, 0, 2'd0, 6'd0); #1;
    for (int i = 0; i < 3; i++) begin
      cyc(); idle(); wb(1'b1, 2'd1); #1;
      check("t4_blocked", rf_rd_en, 4'b0);
    end
    cyc(); idle(); #1;
    check("t4_rden", rf_rd_en, 4'b0010);
    check("t4_row1", rf_rd_row[1], 6'd2);
    cyc(); #1;
    check("t4_vld", bk_vld, 4'b0010);
    check("t4_ocid1", bk_ocid[1], 3'b110);
    check("t4_data1", bk_data[1], rfval(1, 6'd2));

    // fill bank0 while writeback blocks it
    cyc(); alloc(2'd1, 1, 2'd0, 6'd1, 1, 2'd0, 6'd2);
    wb(1'b1, 2'd0); #1;
    check("t5_rdy_a", bus.alloc_rdy, 1'b1);
    cyc(); alloc(2'd1, 1, 2'd0, 6'd3, 1, 2'd0, 6'd4);
    wb(1'b1, 2'd0); #1;
    check("t5_rdy_b", bus.alloc_rdy, 1'b1);
    cyc(); alloc(2'd1, 1, 2'd0, 6'd5, 0, 2'd0, 6'd0);
    wb(1'b1, 2'd0); #1;
    check("t5_full", bus.alloc_rdy, 1'b0);
    check("t5_noread", rf_rd_en, 4'b0);
    alloc(2'd1, 1, 2'd2, 6'd6, 0, 2'd0, 6'd0); #1;
    check("t5_bank2", bus.alloc_rdy, 1'b1);
    cyc(); alloc(2'd1, 1, 2'd0, 6'd5, 0, 2'd0, 6'd0);
    wb(1'b0, 2'd0); #1;
    check("t5_full_pop", bus.alloc_rdy, 1'b0);
    check("t5_rden", rf_rd_en, 4'b0101);
    check("t5_row0", rf_rd_row[0], 6'd1);
    cyc(); idle(); #1;
    check("t5_vld", bk_vld, 4'b0101);
    check("t5_ocid2", bk_ocid[2], 3'b010);
    check("t5_data2", bk_data[2], rfval(2, 6'd6));
    for (int i = 0; i < 4; i++) begin
      check("t5_order_vld", bk_vld[0], 1'b1);
      check("t5_order_ocid", bk_ocid[0], 3'(2 + i % 2));
      check("t5_order_data", bk_data[0], rfval(0, rows[i]));
      cyc(); #1;
    end
    check("t5_drained", bk_vld, 4'b0);

    // reset with three entries queued on bank3
    cyc(); alloc(2'd2, 1, 2'd3, 6'd1, 1, 2'd3, 6'd2);
    wb(1'b1, 2'd3); #1;
    cyc(); alloc(2'd2, 1, 2'd3, 6'd3, 0, 2'd0, 6'd0);
    wb(1'b1, 2'd3); #1;
    cyc(); rst = 1'b1;
    alloc(2'd0, 1, 2'd1, 6'd8, 0, 2'd0, 6'd0);
    wb(1'b1, 2'd3); #1;
    cyc(); #1;
    cyc(); rst = 1'b0; idle(); #1;
    check("t6_rdy", bus.alloc_rdy, 1'b1);
    check("t6_vld0", bk_vld, 4'b0);
    check("t6_rden0", rf_rd_en, 4'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      check("t6_vld", bk_vld, 4'b0);
      check("t6_rden", rf_rd_en, 4'b0);
    end

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
